// File: rtl/scalar_memory.sv
// Purpose: 256x8 program memory filled by a byte-stream loader, then served to a processor bus.
// Latency: bus reads are combinational (zero cycle); writes and loader bytes commit on the rising edge.
// Backpressure: ld_ready is high only while loading; the processor bus has no stall, and rd+wrt together is flagged.
module scalar_memory (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic        rd,
    input  logic        wrt,
    inout  tri   [7:0]  dat,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_hold,
    output logic        bus_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mem [256];
    logic [7:0]  ld_ptr;
    logic        ld_xfer;
    logic        run_rd;
    logic        run_wr;
    logic        run_cfl;
    logic        mem_we;
    logic [7:0]  mem_wa;
    logic [7:0]  mem_wd;

    // Bus qualifiers: only meaningful in RUN, and a simultaneous rd+wrt is neither a read nor a write.
    assign ld_xfer = ld_valid && ld_ready;
    assign run_rd  = (state == RUN) && rd && !wrt;
    assign run_wr  = (state == RUN) && wrt && !rd;
    assign run_cfl = (state == RUN) && rd && wrt;

    // State register; reset always returns to LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: the transfer carrying ld_last hands over to the processor; RUN is terminal until reset.
    always_comb begin
        state_nxt = state;
        if ((state == LOAD) && ld_xfer && ld_last) begin
            state_nxt = RUN;
        end
    end

    // Outputs decoded from state only.
    always_comb begin
        ld_ready = (state == LOAD);
        cpu_hold = (state == LOAD);
    end

    // Loader write pointer, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ptr <= 8'h00;
        end else if (ld_xfer) begin
            ld_ptr <= ld_ptr + 8'h01;
        end
    end

    // Single write port shared by loader (LOAD) and processor (RUN); the two are mutually exclusive by state.
    always_comb begin
        mem_we = ld_xfer || run_wr;
        mem_wa = ld_xfer ? ld_ptr  : addr;
        mem_wd = ld_xfer ? ld_data : dat;
    end

    // Storage is never cleared; a write on an edge where rst is high is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (run_cfl) begin
            bus_err <= 1'b1;
        end
    end

    // Per-edge access counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            if (run_rd && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'h0001;
            end
            if (run_wr && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'h0001;
            end
        end
    end

    // Read data is driven straight from the array so it follows addr within the cycle.
    assign dat = run_rd ? mem[addr] : 8'bz;

endmodule

// File: tb/tb_scalar_memory.sv
module tb_scalar_memory;

    localparam int K_DAT  = 0;
    localparam int K_LDR  = 1;
    localparam int K_HOLD = 2;
    localparam int K_ERR  = 3;
    localparam int K_RDC  = 4;
    localparam int K_WRC  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        rd;
    logic        wrt;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_hold;
    logic        bus_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    // Undriven bus floats to 0xFF so "not driven" is observable.
    tri1  [7:0]  dat;
    logic        tb_oe;
    logic [7:0]  tb_dat;
    assign dat = tb_oe ? tb_dat : 8'bz;

    scalar_memory dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .rd       (rd),
        .wrt      (wrt),
        .dat      (dat),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .bus_err  (bus_err),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       nm;
    } chk_t;

    chk_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        run_exp;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;

    task automatic expect_val(input int kind, input logic [15:0] exp, input string nm);
        chk_t e;
        e.kind = kind;
        e.exp  = exp;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every queued expectation is checked on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_DAT:   act = {8'h00, dat};
                K_LDR:   act = {15'h0000, ld_ready};
                K_HOLD:  act = {15'h0000, cpu_hold};
                K_ERR:   act = {15'h0000, bus_err};
                K_RDC:   act = rd_cnt;
                default: act = wr_cnt;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
            end
        end
    end

    // Advance one cycle; the counter model follows the stimulus applied during that cycle.
    task automatic step();
        if (run_exp && rd && !wrt && (exp_rd != 16'hFFFF)) exp_rd = exp_rd + 16'h0001;
        if (run_exp && wrt && !rd && (exp_wr != 16'hFFFF)) exp_wr = exp_wr + 16'h0001;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (last) run_exp = 1'b1;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] expd, input string nm);
        rd   = 1'b1;
        addr = a;
        expect_val(K_DAT, {8'h00, expd}, nm);
        step();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run_exp = 1'b0;
        exp_rd  = 16'h0000;
        exp_wr  = 16'h0000;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_idle_regs(input string tag);
        expect_val(K_ERR, 16'h0000, {tag, "_bus_err"});
        expect_val(K_RDC, exp_rd,   {tag, "_rd_cnt"});
        expect_val(K_WRC, exp_wr,   {tag, "_wr_cnt"});
    endtask

    initial begin
        rst = 1'b1; addr = 8'h00; rd = 1'b0; wrt = 1'b0;
        ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        tb_oe = 1'b0; tb_dat = 8'h00;
        run_exp = 1'b0; exp_rd = 16'h0000; exp_wr = 16'h0000;

        // Reset state
        expect_val(K_LDR,  16'h0001, "rst_ld_ready");
        expect_val(K_HOLD, 16'h0001, "rst_cpu_hold");
        expect_val(K_DAT,  16'h00FF, "rst_dat_z");
        chk_idle_regs("rst");
        step();
        do_reset();

        // ld_last without ld_valid does nothing; bus is ignored in LOAD
        ld_last = 1'b1; rd = 1'b1; addr = 8'h00;
        expect_val(K_DAT, 16'h00FF, "load_rd_ignored");
        step();
        ld_last = 1'b0; rd = 1'b0;
        expect_val(K_HOLD, 16'h0001, "last_no_valid_hold");

        // Three-byte load
        load(8'h20, 1'b0);
        load(8'h51, 1'b0);
        expect_val(K_HOLD, 16'h0001, "hold_before_last");
        load(8'h00, 1'b1);
        expect_val(K_HOLD, 16'h0000, "run_cpu_hold");
        expect_val(K_LDR,  16'h0000, "run_ld_ready");
        rd_chk(8'h01, 8'h51, "rd_01");
        rd_chk(8'h00, 8'h20, "rd_00");
        rd_chk(8'h02, 8'h00, "rd_02");

        // Processor write then read back
        wrt = 1'b1; addr = 8'h80; tb_oe = 1'b1; tb_dat = 8'hA5;
        expect_val(K_WRC, exp_wr, "wr_cnt_before");
        step();
        wrt = 1'b0; tb_oe = 1'b0;
        expect_val(K_WRC, exp_wr, "wr_cnt_after");
        expect_val(K_RDC, exp_rd, "rd_cnt_3");
        rd_chk(8'h80, 8'hA5, "rd_80_written");
        expect_val(K_RDC, exp_rd, "rd_cnt_4");

        // Conflict: no write, no drive, sticky flag
        rd = 1'b1; wrt = 1'b1; addr = 8'h80; tb_oe = 1'b1; tb_dat = 8'h3C;
        expect_val(K_ERR, 16'h0000, "err_before_cfl");
        step();
        tb_oe = 1'b0;
        expect_val(K_DAT, 16'h00FF, "cfl_dat_z");
        expect_val(K_ERR, 16'h0001, "err_set");
        step();
        rd = 1'b0; wrt = 1'b0;
        for (int i = 0; i < 10; i++) step();
        expect_val(K_ERR, 16'h0001, "err_sticky");
        expect_val(K_RDC, exp_rd,   "cfl_rd_cnt");
        expect_val(K_WRC, exp_wr,   "cfl_wr_cnt");
        rd_chk(8'h80, 8'hA5, "rd_80_after_cfl");

        // Async reset in RUN with a coincident write to 0x01
        rst = 1'b1; run_exp = 1'b0; exp_rd = 16'h0000; exp_wr = 16'h0000;
        wrt = 1'b1; addr = 8'h01; tb_oe = 1'b1; tb_dat = 8'h99;
        expect_val(K_HOLD, 16'h0001, "async_rst_hold");
        expect_val(K_LDR,  16'h0001, "async_rst_ld_ready");
        chk_idle_regs("async_rst");
        step();
        rst = 1'b0; wrt = 1'b0; tb_oe = 1'b0;
        expect_val(K_DAT, 16'h00FF, "post_rst_dat_z");
        load(8'hAA, 1'b1);
        rd_chk(8'h01, 8'h51, "rd_01_kept");
        rd_chk(8'h00, 8'hAA, "rd_00_reload");

        // Reset mid-load restarts at address 0
        do_reset();
        load(8'h11, 1'b0);
        load(8'h22, 1'b0);
        load(8'h33, 1'b0);
        do_reset();
        load(8'h77, 1'b1);
        chk_idle_regs("midload");
        rd_chk(8'h00, 8'h77, "ml_rd_00");
        rd_chk(8'h01, 8'h22, "ml_rd_01");
        rd_chk(8'h02, 8'h33, "ml_rd_02");

        // Pointer wrap over 257 bytes
        do_reset();
        for (int i = 0; i < 256; i++) load(8'(i), 1'b0);
        expect_val(K_HOLD, 16'h0001, "wrap_still_load");
        load(8'hEE, 1'b1);
        rd_chk(8'h00, 8'hEE, "wrap_rd_00");
        rd_chk(8'hFF, 8'hFF, "wrap_rd_ff");
        rd_chk(8'h7F, 8'h7F, "wrap_rd_7f");
        rd_chk(8'h01, 8'h01, "wrap_rd_01");

        // Read counter saturation
        rd = 1'b1; addr = 8'hFF;
        for (int i = 0; i < 65540; i++) begin
            if (exp_rd == 16'hFFFE) expect_val(K_RDC, exp_rd, "rd_cnt_fffe");
            step();
        end
        rd = 1'b0;
        expect_val(K_RDC, 16'hFFFF, "rd_cnt_sat");
        expect_val(K_WRC, exp_wr,   "sat_wr_cnt");
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
